// File: rtl/tx_short_pre_gen_if.sv
// Sample stream from the STF sequencer to the TX sample mux.
//   master: drives out_valid, out_i, out_q, out_last; reads out_ready
//   slave : reads the sample fields; drives out_ready
interface tx_short_pre_gen_if #(
    parameter int unsigned DW = 10
) ();
    logic          out_valid;
    logic          out_ready;
    logic [DW-1:0] out_i;
    logic [DW-1:0] out_q;
    logic          out_last;

    modport master (
        output out_valid,
        output out_i,
        output out_q,
        output out_last,
        input  out_ready
    );

    modport slave (
        input  out_valid,
        input  out_i,
        input  out_q,
        input  out_last,
        output out_ready
    );
endinterface

// File: rtl/tx_short_pre_gen.sv
// 802.11a short training field sequencer.
// Walks the short-preamble ROM index through NUM_REP 16-sample periods.
// Each ROM sample is registered and streamed over a valid/ready interface.
// out_last marks the final sample, and done pulses once after that sample transfers.
// Optional macro TX_SP_WINDOW_EN enables edge windowing:
//   - sample 0 is halved
//   - a halved index-0 overlap sample is appended
// Ports:
//   clk, rst          rising-edge clock, synchronous active-high reset
//   start             single-cycle burst request (ignored unless idle)
//   busy              burst in progress (RUN, DRAIN, DONE)
//   sp_index          ROM index; sp_i_in/sp_q_in are the ROM's same-cycle output
//   out_if (master)   out_valid/out_ready/out_i/out_q/out_last sample stream
//   done              one-cycle pulse after the last transfer
module tx_short_pre_gen #(
    parameter int unsigned NUM_REP = 10,
    parameter int unsigned DW      = 10
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start,
    output logic                    busy,
    output logic [3:0]              sp_index,
    input  logic [DW-1:0]           sp_i_in,
    input  logic [DW-1:0]           sp_q_in,
    tx_short_pre_gen_if.master      out_if,
    output logic                    done
);

`ifdef TX_SP_WINDOW_EN
    localparam int unsigned N_TOTAL = NUM_REP * 16 + 1;
`else
    localparam int unsigned N_TOTAL = NUM_REP * 16;
`endif
    // Counter also holds the post-final value N_TOTAL.
    localparam int unsigned CNT_W = $clog2(N_TOTAL + 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DRAIN,
        S_DONE
    } state_e;

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             vld_q, vld_d;
    logic [DW-1:0]    i_q, i_d;
    logic [DW-1:0]    q_q, q_d;
    logic             last_q, last_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;

    logic load;
    logic xfer;
    logic is_final;

    // Next-state and datapath
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        vld_d    = vld_q;
        i_d      = i_q;
        q_d      = q_q;
        last_d   = last_q;

        load     = (state_q == S_RUN) && (!vld_q || out_if.out_ready);
        xfer     = vld_q && out_if.out_ready;
        is_final = (cnt_q == CNT_W'(N_TOTAL - 1));

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_RUN;
                    cnt_d   = '0;
                end
            end
            S_RUN: begin
                if (load && is_final) state_d = S_DRAIN;
            end
            S_DRAIN: begin
                if (xfer && last_q) state_d = S_DONE;
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase

        if (load) begin
`ifdef TX_SP_WINDOW_EN
            // Burst edges are halved: arithmetic shift, rounds toward -inf.
            if ((cnt_q == '0) || is_final) begin
                i_d = DW'($signed(sp_i_in) >>> 1);
                q_d = DW'($signed(sp_q_in) >>> 1);
            end else begin
                i_d = sp_i_in;
                q_d = sp_q_in;
            end
`else
            i_d = sp_i_in;
            q_d = sp_q_in;
`endif
            vld_d  = 1'b1;
            last_d = is_final;
            cnt_d  = cnt_q + CNT_W'(1);
        end else if (xfer) begin
            vld_d  = 1'b0;
            last_d = 1'b0;
        end

        busy_d = (state_d != S_IDLE);
        done_d = (state_d == S_DONE);
    end

    // State and output registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            vld_q   <= 1'b0;
            i_q     <= '0;
            q_q     <= '0;
            last_q  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            vld_q   <= vld_d;
            i_q     <= i_d;
            q_q     <= q_d;
            last_q  <= last_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    // Index wraps 15->0 each period.
    // With windowing, the appended sample lands on index 0 because N_TOTAL-1 is a multiple of 16.
    assign sp_index         = cnt_q[3:0];
    assign busy             = busy_q;
    assign done             = done_q;
    assign out_if.out_valid = vld_q;
    assign out_if.out_i     = i_q;
    assign out_if.out_q     = q_q;
    assign out_if.out_last  = last_q;

endmodule

// File: tb/tb_tx_short_pre_gen.sv
module tb_tx_short_pre_gen;

`ifdef TX_SP_WINDOW_EN
    localparam int unsigned N_EXP = 161;
    localparam bit          WIN   = 1'b1;
`else
    localparam int unsigned N_EXP = 160;
    localparam bit          WIN   = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic       busy;
    logic       done;
    logic [3:0] sp_index;
    logic [9:0] sp_i_in;
    logic [9:0] sp_q_in;

    tx_short_pre_gen_if #(.DW(10)) sif ();

    tx_short_pre_gen #(.NUM_REP(10), .DW(10)) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .busy     (busy),
        .sp_index (sp_index),
        .sp_i_in  (sp_i_in),
        .sp_q_in  (sp_q_in),
        .out_if   (sif),
        .done     (done)
    );

    always #5 clk = ~clk;

    // Short-preamble ROM (scaled 802.11a STF)
    logic signed [9:0] rom_i [16];
    logic signed [9:0] rom_q [16];
    assign sp_i_in = rom_i[sp_index];
    assign sp_q_in = rom_q[sp_index];

    // Reference stream: sample k = ROM[k mod 16], edges halved when windowed
    logic signed [9:0] exp_i [N_EXP];
    logic signed [9:0] exp_q [N_EXP];

    int n_checks = 0;
    int n_pass   = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    endtask

    task automatic spec_pt(input string tag, input int ei, input int eq);
        logic [9:0] ti;
        logic [9:0] tq;
        ti = 10'(ei);
        tq = 10'(eq);
        chk({tag, "_i"}, {22'd0, sif.out_i}, {22'd0, ti});
        chk({tag, "_q"}, {22'd0, sif.out_q}, {22'd0, tq});
    endtask

    // mode 0: ready=1, 1: random ready + stray starts, 2: 3-cycle stall on sample 9, 3: reset at sample 70
    task automatic run_burst(input int mode);
        int         pos;
        int         stall;
        bit         r;
        bit         prev_final;
        bit         done_seen;
        bit         aborted;
        logic [9:0] hold_i;
        logic [9:0] hold_q;
        logic [3:0] hold_idx;
        pos = 0; stall = 0; prev_final = 0; done_seen = 0; aborted = 0;
        hold_i = '0; hold_q = '0; hold_idx = '0;

        @(negedge clk);
        start = 1'b1;
        sif.out_ready = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("lat_valid0", 32'(sif.out_valid), 32'd0);
        chk("lat_busy", 32'(busy), 32'd1);
        @(negedge clk);
        chk("lat_valid1", 32'(sif.out_valid), 32'd1);

        for (int cyc = 0; cyc < 4000 && !done_seen; cyc++) begin
            if (mode == 3 && pos == 70 && sif.out_valid) begin
                rst = 1'b1;
                sif.out_ready = 1'b1;
                @(negedge clk);
                rst = 1'b0;
                chk("rst_valid", 32'(sif.out_valid), 32'd0);
                chk("rst_busy", 32'(busy), 32'd0);
                chk("rst_done", 32'(done), 32'd0);
                chk("rst_last", 32'(sif.out_last), 32'd0);
                chk("rst_i", 32'(sif.out_i), 32'd0);
                chk("rst_idx", 32'(sp_index), 32'd0);
                aborted = 1;
                break;
            end

            start = (mode == 1) && (cyc == 50 || prev_final);

            r = 1'b1;
            if (mode == 1) r = 1'($urandom_range(0, 1));
            if (mode == 2 && pos == 9 && sif.out_valid) begin
                if (stall == 0) begin
                    hold_i = sif.out_i; hold_q = sif.out_q; hold_idx = sp_index;
                end else begin
                    chk("bp_i", 32'(sif.out_i), 32'(hold_i));
                    chk("bp_q", 32'(sif.out_q), 32'(hold_q));
                    chk("bp_idx", 32'(sp_index), 32'(hold_idx));
                end
                if (stall < 3) r = 1'b0;
                stall++;
            end
            sif.out_ready = r;

            chk("done", 32'(done), 32'(prev_final));
            chk("busy", 32'(busy), 32'd1);
            if (prev_final) done_seen = 1;
            prev_final = 0;

            if (sif.out_valid && r) begin
                if (pos < N_EXP) begin
                    chk("s_i", {22'd0, sif.out_i}, {22'd0, exp_i[pos]});
                    chk("s_q", {22'd0, sif.out_q}, {22'd0, exp_q[pos]});
                    chk("s_last", 32'(sif.out_last), 32'(pos == N_EXP - 1));
                    case (pos)
                        0:  spec_pt("s0", WIN ? 23 : 47, WIN ? 23 : 47);
                        1:  spec_pt("s1", -136, 2);
                        4:  spec_pt("s4", 94, 0);
                        9:  spec_pt("s9", 2, -136);
                        16: spec_pt("s16", 47, 47);
                        default: ;
                    endcase
                    if (WIN && pos == N_EXP - 1) spec_pt("s_app", 23, 23);
                end else begin
                    chk("overrun", 32'(pos), 32'(N_EXP - 1));
                end
                prev_final = (pos == N_EXP - 1);
                pos++;
            end
            @(negedge clk);
        end
        start = 1'b0;
        sif.out_ready = 1'b1;

        if (aborted) begin
            repeat (5) begin
                @(negedge clk);
                chk("post_rst_done", 32'(done), 32'd0);
                chk("post_rst_busy", 32'(busy), 32'd0);
            end
        end else begin
            chk("count", 32'(pos), 32'(N_EXP));
            chk("done_seen", 32'(done_seen), 32'd1);
            chk("idle_busy", 32'(busy), 32'd0);
            chk("idle_done", 32'(done), 32'd0);
            chk("idle_valid", 32'(sif.out_valid), 32'd0);
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin
        rom_i = '{47, -136, -14, 146, 94, 146, -14, -136, 47, 2, -81, -14, 0, -14, -81, 2};
        rom_q = '{47, 2, -81, -14, 0, -14, -81, 2, 47, -136, -14, 146, 94, 146, -14, -136};
        for (int k = 0; k < int'(N_EXP); k++) begin
            logic signed [9:0] vi;
            logic signed [9:0] vq;
            vi = rom_i[k % 16];
            vq = rom_q[k % 16];
            if (WIN && (k == 0 || k == int'(N_EXP) - 1)) begin
                vi = vi >>> 1;
                vq = vq >>> 1;
            end
            exp_i[k] = vi;
            exp_q[k] = vq;
        end

        rst = 1'b1;
        start = 1'b0;
        sif.out_ready = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        repeat (10) @(negedge clk);
        chk("rst_out_valid", 32'(sif.out_valid), 32'd0);
        chk("rst_out_i", 32'(sif.out_i), 32'd0);
        chk("rst_out_q", 32'(sif.out_q), 32'd0);
        chk("rst_busy0", 32'(busy), 32'd0);
        chk("rst_done0", 32'(done), 32'd0);
        chk("rst_index", 32'(sp_index), 32'd0);

        // start together with rst: reset wins
        rst = 1'b1;
        start = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        start = 1'b0;
        chk("rs_busy", 32'(busy), 32'd0);
        @(negedge clk);
        chk("rs_busy2", 32'(busy), 32'd0);
        chk("rs_valid", 32'(sif.out_valid), 32'd0);

        run_burst(0);
        run_burst(2);
        run_burst(1);
        run_burst(3);
        run_burst(0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
